// File: rtl/chu_led_pwm.sv
// chu_led_pwm: per-LED 8-bit PWM brightness behind the GPO on/off pattern.
// Ports: clk/rst (async, active-high), slot bus cs/read/write/addr/wr_data/rd_data,
//   led_en (GPO pattern in), led_out (registered PWM drive out).
// Map: 0..N_LED-1 DUTY, 16 PRESC, 17 CTRL (bit0 enable), 18/19 blink half/mask.
// Optional blink gating is compiled in with `define CHU_LED_PWM_BLINK_EN.
module chu_led_pwm #(
  parameter int N_LED = 4,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             read,
  input  logic             write,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [N_LED-1:0] led_en,
  output logic [N_LED-1:0] led_out
);
  logic [7:0]       duty_q [N_LED];
  logic [7:0]       sh_q [N_LED];
  logic [PRE_W-1:0] presc_q, pre_q;
  logic [7:0]       pwm_q;
  logic             en_q;
  logic [N_LED-1:0] led_q, led_d, bl_ok;
  logic             we, tick, pe;
  logic             unused_ok;
  assign unused_ok = ^{read, wr_data};
  assign we   = cs && write;
  assign tick = en_q && (pre_q == presc_q);
  assign pe   = tick && (pwm_q == 8'hFF);
  assign led_out = led_q;
`ifdef CHU_LED_PWM_BLINK_EN
  logic [15:0]      half_q, bcnt_q;
  logic [N_LED-1:0] mask_q;
  logic             ph_q;
  assign bl_ok = ~mask_q | {N_LED{ph_q}};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      half_q <= '0;
      bcnt_q <= '0;
      mask_q <= '0;
      ph_q   <= 1'b1;
    end else begin
      if (we && addr == 5'd19) mask_q <= wr_data[N_LED-1:0];
      if (we && addr == 5'd18) begin
        half_q <= wr_data[15:0];
        bcnt_q <= '0;
        ph_q   <= 1'b1;
      end else if (pe) begin
        if (half_q == '0) begin
          bcnt_q <= '0;
          ph_q   <= 1'b1;
        end else if (bcnt_q == half_q - 16'd1) begin
          bcnt_q <= '0;
          ph_q   <= ~ph_q;
        end else begin
          bcnt_q <= bcnt_q + 16'd1;
        end
      end
    end
`else
  assign bl_ok = '1;
`endif
  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LED; i++)
      led_d[i] = en_q && led_en[i] && bl_ok[i] && (sh_q[i] == 8'hFF || pwm_q < sh_q[i]);
  end
  // Read returns the pending DUTY values, never the active shadows.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_LED; i++)
      if (addr == 5'(i)) rd_data = {24'b0, duty_q[i]};
    if (addr == 5'd16) rd_data = 32'(presc_q);
    if (addr == 5'd17) rd_data = {31'b0, en_q};
`ifdef CHU_LED_PWM_BLINK_EN
    if (addr == 5'd18) rd_data = {16'b0, half_q};
    if (addr == 5'd19) rd_data = 32'(mask_q);
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc_q <= '0;
      pre_q   <= '0;
      pwm_q   <= '0;
      en_q    <= 1'b0;
      led_q   <= '0;
      for (int i = 0; i < N_LED; i++) begin
        duty_q[i] <= '0;
        sh_q[i]   <= '0;
      end
    end else begin
      pre_q <= (!en_q || tick || (we && addr == 5'd16)) ? '0 : pre_q + 1'b1;
      pwm_q <= !en_q ? '0 : pwm_q + 8'(tick);
      led_q <= led_d;
      // Shadows track DUTY while disabled so re-enable starts on current values;
      // otherwise they only move at period end, taking the pre-write DUTY.
      for (int i = 0; i < N_LED; i++) begin
        if (!en_q || pe) sh_q[i] <= duty_q[i];
        if (we && addr == 5'(i)) duty_q[i] <= wr_data[7:0];
      end
      if (we && addr == 5'd16) presc_q <= wr_data[PRE_W-1:0];
      if (we && addr == 5'd17) en_q <= wr_data[0];
    end
endmodule

// File: tb/tb_chu_led_pwm.sv
// tb_chu_led_pwm: randomized and directed checks of chu_led_pwm against a cycle model.
module tb_chu_led_pwm;
  localparam int N = 4;
  logic clk = 0, rst = 1, cs = 0, read = 0, write = 0;
  logic [4:0] addr = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic [N-1:0] led_en = 0, led_out;
  int checks = 0, fails = 0;
  int m_duty[N], m_sh[N];
  int m_presc, m_en, m_pre, m_pwm, m_half, m_bcnt;
  logic [N-1:0] m_led, m_mask;
  logic m_ph;

  chu_led_pwm #(.N_LED(N), .PRE_W(16)) dut (
    .clk(clk), .rst(rst), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .led_en(led_en), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_duty[i] = 0; m_sh[i] = 0; end
    m_presc = 0; m_en = 0; m_pre = 0; m_pwm = 0; m_half = 0; m_bcnt = 0;
    m_led = 0; m_mask = 0; m_ph = 1;
  endtask

  function automatic int exp_rd(int a);
    if (a < N) return m_duty[a];
    if (a == 16) return m_presc;
    if (a == 17) return m_en;
`ifdef CHU_LED_PWM_BLINK_EN
    if (a == 18) return m_half;
    if (a == 19) return int'(m_mask);
`endif
    return 0;
  endfunction

  // One clock with an optional bus write; advances DUT and model together.
  task automatic cyc(input bit w, input int a, input int d);
    bit tick, pe;
    logic [N-1:0] nl;
    cs = w; write = w; addr = a[4:0]; wr_data = d;
    tick = m_en != 0 && m_pre == m_presc;
    pe = tick && m_pwm == 255;
    for (int i = 0; i < N; i++)
      nl[i] = m_en != 0 && led_en[i] && (m_sh[i] == 255 || m_pwm < m_sh[i]) && (!m_mask[i] || m_ph);
    @(posedge clk); #1;
    m_led = nl;
    for (int i = 0; i < N; i++) if (m_en == 0 || pe) m_sh[i] = m_duty[i];
    m_pre = (m_en == 0 || tick || (w && a == 16)) ? 0 : m_pre + 1;
    m_pwm = (m_en == 0) ? 0 : (m_pwm + int'(tick)) % 256;
`ifdef CHU_LED_PWM_BLINK_EN
    if (w && a == 18) begin m_half = d & 32'hFFFF; m_bcnt = 0; m_ph = 1; end
    else if (pe && m_half != 0) begin
      m_bcnt++;
      if (m_bcnt == m_half) begin m_bcnt = 0; m_ph = !m_ph; end
    end
    if (w && a == 19) m_mask = d[N-1:0];
`endif
    if (w && a < N) m_duty[a] = d & 255;
    if (w && a == 16) m_presc = d & 32'hFFFF;
    if (w && a == 17) m_en = d & 1;
    cs = 0; write = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (led_out !== '0) begin fails++; $display("FAIL reset_led got=%b exp=0", led_out); end
    for (int a = 0; a < 32; a++) begin
      addr = a[4:0]; #1;
      checks++;
      if (rd_data !== 32'd0) begin fails++; $display("FAIL reset_rd addr=%0d got=%0h exp=0", a, rd_data); end
    end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_duty64();
    int hi, oth;
    led_en = 4'b0001;
    cyc(1, 0, 64); cyc(1, 16, 0); cyc(1, 17, 1);
    for (int n = 0; n < 300; n++) begin
      cyc(0, 0, 0); checks++;
      if (led_out !== m_led) begin fails++; $display("FAIL duty64_cyc n=%0d got=%b exp=%b", n, led_out, m_led); end
    end
    hi = 0; oth = 0;
    for (int n = 0; n < 256; n++) begin
      cyc(0, 0, 0); hi += int'(led_out[0]); oth += int'(|led_out[N-1:1]);
    end
    checks++;
    if (hi != 64) begin fails++; $display("FAIL duty64_count got=%0d exp=64", hi); end
    checks++;
    if (oth != 0) begin fails++; $display("FAIL duty64_others got=%0d exp=0", oth); end
  endtask

  task automatic test_const();
    int on1, on2;
    led_en = 4'b1111;
    cyc(1, 1, 0); cyc(1, 2, 255);
    for (int n = 0; n < 600; n++) begin
      cyc(0, 0, 0); checks++;
      if (led_out !== m_led) begin fails++; $display("FAIL const_cyc n=%0d got=%b exp=%b", n, led_out, m_led); end
    end
    on1 = 0; on2 = 0;
    for (int n = 0; n < 256; n++) begin
      cyc(0, 0, 0); on1 += int'(led_out[1]); on2 += int'(led_out[2]);
    end
    checks++;
    if (on1 != 0) begin fails++; $display("FAIL duty0_on got=%0d exp=0", on1); end
    checks++;
    if (on2 != 256) begin fails++; $display("FAIL duty255_on got=%0d exp=256", on2); end
  endtask

  task automatic test_presc_update();
    int hi;
    led_en = 4'b0001;
    cyc(1, 16, 3); cyc(1, 0, 128);
    for (int n = 0; n < 1100; n++) begin
      cyc(0, 0, 0); checks++;
      if (led_out !== m_led) begin fails++; $display("FAIL presc_cyc n=%0d got=%b exp=%b", n, led_out, m_led); end
    end
    hi = 0;
    for (int n = 0; n < 1024; n++) begin cyc(0, 0, 0); hi += int'(led_out[0]); end
    checks++;
    if (hi != 512) begin fails++; $display("FAIL presc_count got=%0d exp=512", hi); end
    for (int n = 0; n < 300; n++) cyc(0, 0, 0);
    cyc(1, 0, 32);
    checks++;
    if (rd_data !== 32'd32) begin fails++; $display("FAIL pending_rd got=%0d exp=32", rd_data); end
    for (int n = 0; n < 2100; n++) begin
      cyc(0, 0, 0); checks++;
      if (led_out !== m_led) begin fails++; $display("FAIL update_cyc n=%0d got=%b exp=%b", n, led_out, m_led); end
    end
    hi = 0;
    for (int n = 0; n < 1024; n++) begin cyc(0, 0, 0); hi += int'(led_out[0]); end
    checks++;
    if (hi != 128) begin fails++; $display("FAIL update_count got=%0d exp=128", hi); end
  endtask

  task automatic test_disable();
    led_en = 4'b1111;
    cyc(1, 0, 255);
    for (int n = 0; n < 1100; n++) cyc(0, 0, 0);
    checks++;
    if (led_out !== m_led) begin fails++; $display("FAIL pre_dis got=%b exp=%b", led_out, m_led); end
    cyc(1, 17, 0); cyc(0, 0, 0);
    checks++;
    if (led_out !== 4'b0000) begin fails++; $display("FAIL disable_led got=%b exp=0000", led_out); end
    cyc(1, 0, 200); cyc(1, 16, 0);
    addr = 17; #1; checks++;
    if (rd_data !== 32'd0) begin fails++; $display("FAIL ctrl_rd got=%0d exp=0", rd_data); end
    cyc(1, 17, 1);
    for (int n = 0; n < 600; n++) begin
      cyc(0, 0, 0); checks++;
      if (led_out !== m_led) begin fails++; $display("FAIL reen_cyc n=%0d got=%b exp=%b", n, led_out, m_led); end
    end
  endtask

  task automatic test_blink();
`ifdef CHU_LED_PWM_BLINK_EN
    int hi;
    led_en = 4'b0001;
    cyc(1, 16, 0); cyc(1, 0, 255); cyc(1, 19, 1); cyc(1, 18, 2);
    for (int n = 0; n < 2100; n++) begin
      cyc(0, 0, 0); checks++;
      if (led_out !== m_led) begin fails++; $display("FAIL blink_cyc n=%0d got=%b exp=%b", n, led_out, m_led); end
    end
    hi = 0;
    for (int n = 0; n < 1024; n++) begin cyc(0, 0, 0); hi += int'(led_out[0]); end
    checks++;
    if (hi != 512) begin fails++; $display("FAIL blink_count got=%0d exp=512", hi); end
`else
    cyc(1, 18, 2); cyc(1, 19, 1);
    addr = 18; #1; checks++;
    if (rd_data !== 32'd0) begin fails++; $display("FAIL blink_rd18 got=%0d exp=0", rd_data); end
    addr = 19; #1; checks++;
    if (rd_data !== 32'd0) begin fails++; $display("FAIL blink_rd19 got=%0d exp=0", rd_data); end
`endif
  endtask

  task automatic test_random();
    int a, d, len, ra;
    for (int it = 0; it < 25; it++) begin
      a = $urandom_range(0, 19);
      d = int'($urandom);
      if (a == 16) d = $urandom_range(0, 3);
      if (a == 17) d = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if (a == 18) d = $urandom_range(0, 3);
      cyc(1, a, d);
      led_en = N'($urandom);
      len = $urandom_range(50, 400);
      for (int n = 0; n < len; n++) begin
        cyc(0, 0, 0); checks++;
        if (led_out !== m_led) begin fails++; $display("FAIL rand_cyc it=%0d n=%0d got=%b exp=%b", it, n, led_out, m_led); end
      end
      ra = $urandom_range(0, 31);
      addr = ra[4:0]; #1; checks++;
      if (rd_data !== 32'(exp_rd(ra))) begin fails++; $display("FAIL rand_rd addr=%0d got=%0h exp=%0h", ra, rd_data, exp_rd(ra)); end
    end
  endtask

  task automatic test_async_reset();
    led_en = 4'b1111;
    cyc(1, 17, 1); cyc(1, 16, 0);
    for (int i = 0; i < N; i++) cyc(1, i, 255);
    for (int n = 0; n < 600; n++) cyc(0, 0, 0);
    checks++;
    if (led_out !== 4'b1111) begin fails++; $display("FAIL pre_rst got=%b exp=1111", led_out); end
    #3 rst = 1; #1;
    model_reset();
    checks++;
    if (led_out !== '0) begin fails++; $display("FAIL async_rst_led got=%b exp=0", led_out); end
    addr = 0; #1; checks++;
    if (rd_data !== 32'd0) begin fails++; $display("FAIL async_rst_rd got=%0h exp=0", rd_data); end
    @(posedge clk); #1; rst = 0;
    for (int n = 0; n < 100; n++) begin
      cyc(0, 0, 0); checks++;
      if (led_out !== m_led) begin fails++; $display("FAIL post_rst n=%0d got=%b exp=%b", n, led_out, m_led); end
    end
  endtask

  initial begin
    test_reset();
    test_duty64();
    test_const();
    test_presc_update();
    test_disable();
    test_blink();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
